fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register.
- Holds the PC and issues requests to instruction memory over a valid/ready interface with one outstanding request.
- Delivers instr_ID, pc_ID and pc4_ID to the decode stage. The control unit decodes instr_ID directly.
- Handles decode stalls with a one-entry hold buffer. Handles redirects from branch/jal/jalr resolution by flushing and discarding in-flight responses.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded at reset.
- NOP_INSTR, 32'h0000_0013, instruction (addi x0,x0,0) driven on instr_ID for bubbles and flushes.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request this cycle
- imem_addr  out  32  fetch address, equal to pc_F
- imem_rsp_valid  in  1  response data valid; arrives no earlier than the cycle after acceptance
- imem_rsp_data  in  32  fetched instruction word
- redirect_valid  in  1  taken branch/jal/jalr; redirect pipeline
- redirect_pc  in  32  redirect target; bits [1:0] ignored, treated as 0
- stall_ID  in  1  decode cannot accept a new instruction; hold IF/ID
- instr_ID  out  32  instruction to decode/control unit
- pc_ID  out  32  PC of instr_ID
- pc4_ID  out  32  pc_ID+4, used for jal/jalr link writeback
- valid_ID  out  1  instr_ID is a real instruction, not a bubble

Behaviour:
- Reset (async, rst=1):
  - state=FETCH, pc_F=RESET_PC, drop=0, hold buffer empty.
  - valid_ID=0, instr_ID=NOP_INSTR, pc_ID=RESET_PC, pc4_ID=RESET_PC+4.
  - imem_req_valid=0 while rst is high.
- State machine, states FETCH, WAIT, HOLD:
  - FETCH:
    - imem_req_valid = !redirect_valid.
    - If redirect_valid: pc_F<=redirect_pc, stay in FETCH.
    - Else if imem_req_ready: req_pc<=pc_F, pc_F<=pc_F+4, go to WAIT.
  - WAIT (imem_req_valid=0):
    - Redirect without response: pc_F<=redirect_pc, drop<=1, stay in WAIT.
    - Redirect in the same cycle as the response: discard the response, pc_F<=redirect_pc, go to FETCH.
    - Response with drop=1: discard, drop<=0, go to FETCH.
    - Response, no drop, stall_ID=0: load IF/ID with {rsp_data, req_pc}, valid_ID<=1, go to FETCH.
    - Response, no drop, stall_ID=1: store into hold buffer, go to HOLD.
  - HOLD (imem_req_valid=0):
    - redirect_valid: discard hold, pc_F<=redirect_pc, go to FETCH.
    - Else if stall_ID=0: move hold into IF/ID, valid_ID<=1, go to FETCH.
- IF/ID register, priority from highest:
  1. redirect_valid: flush (instr_ID<=NOP_INSTR, valid_ID<=0). Redirect overrides stall_ID.
  2. stall_ID: hold all IF/ID outputs.
  3. New instruction delivered: load it.
  4. Otherwise: bubble (NOP_INSTR, valid_ID=0). pc_ID/pc4_ID keep their last value.
- Arithmetic: 32-bit modular. 32'hFFFF_FFFC+4 wraps to 0, and pc4_ID wraps the same way.
- Throughput: one instruction every two cycles at best (FETCH+WAIT with 1-cycle memory). Latency from request acceptance to valid_ID is 2 edges with no stall.
- Memory ordering: at most one outstanding request. Never more than one response per accepted request.
- Reset mid-request: state is cleared. A response arriving after reset deassertion while in FETCH is ignored; imem_rsp_valid is only sampled in WAIT.

Decomposition:
- Def.v gains `NOP_INSTR, `RESET_PC and the state encodings `FS_FETCH/`FS_WAIT/`FS_HOLD (2 bits).
- One sub-module: if_id_reg, the pipeline register with flush/stall/load/bubble priority and NOP_INSTR insertion.
- FSM, PC and hold buffer stay in fetch_stage.

Test Plan:
- Reset then sequential fetch, ready=1, 1-cycle response returns 0x00500093 @0, 0x00100113 @4 → instr_ID/pc_ID = 0x00500093/0 then 0x00100113/4, pc4_ID=4 then 8, valid_ID toggles 1,0 (bubble in between).
- stall_ID=1 for 3 cycles while a response arrives → state HOLD, imem_req_valid=0, IF/ID unchanged. After release the held word appears with the correct pc_ID and fetch resumes at the next PC.
- redirect_valid with redirect_pc=0x100 in WAIT, response two cycles later → response discarded (valid_ID stays 0). Next imem_addr=0x100, and instr at 0x100 delivers with pc_ID=0x100.
- redirect_valid and imem_rsp_valid in the same cycle, plus stall_ID=1 → IF/ID flushed to NOP, valid_ID=0, response dropped, next request at the redirect target.
- imem_req_ready=0 for 4 cycles → imem_req_valid held at 1, imem_addr stable, pc_F unchanged. redirect_pc=0x203 yields imem_addr=0x200.
- PC wrap: redirect to 0xFFFF_FFFC, fetch one instruction → pc4_ID=0, next imem_addr=0. Assert rst during WAIT → all outputs at reset values immediately.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared constants, state encoding and PC helper for the fetch stage
package fetch_stage_pkg;
   localparam logic [31:0] DEF_RESET_PC  = 32'h0000_0000;
   localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      FS_FETCH = 2'd0,
      FS_WAIT  = 2'd1,
      FS_HOLD  = 2'd2
   } fs_state_t;

   function automatic logic [31:0] align_pc(input logic [31:0] pc);
      return {pc[31:2], 2'b00};
   endfunction
endpackage

// File: rtl/fetch_stage_if_id.sv
// rtl/fetch_stage_if_id.sv - IF/ID pipeline register with flush > stall > load > bubble priority
module if_id_reg
   import fetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
   parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        stall,
   input  logic        load,
   input  logic [31:0] load_instr,
   input  logic [31:0] load_pc,
   output logic [31:0] instr,
   output logic [31:0] pc,
   output logic [31:0] pc4,
   output logic        valid
);
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         instr <= NOP_INSTR;
         pc    <= RESET_PC;
         pc4   <= RESET_PC + 32'd4;
         valid <= 1'b0;
      end else if (flush) begin
         instr <= NOP_INSTR;
         valid <= 1'b0;
      end else if (!stall) begin
         if (load) begin
            instr <= load_instr;
            pc    <= load_pc;
            pc4   <= load_pc + 32'd4;
            valid <= 1'b1;
         end else begin
            // bubble keeps pc/pc4 so a later stall sees a stable link value
            instr <= NOP_INSTR;
            valid <= 1'b0;
         end
      end
   end
endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC, single-outstanding imem request FSM, hold buffer and IF/ID register
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
   parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        stall_ID,
   output logic [31:0] instr_ID,
   output logic [31:0] pc_ID,
   output logic [31:0] pc4_ID,
   output logic        valid_ID
);
   fs_state_t   state;
   logic [31:0] pc_f;
   logic [31:0] req_pc;
   logic        drop;
   logic [31:0] hold_instr;
   logic [31:0] hold_pc;
   logic [31:0] target;
   logic        deliver;
   logic [31:0] deliver_instr;
   logic [31:0] deliver_pc;

   assign target         = align_pc(redirect_pc);
   assign imem_addr      = pc_f;
   assign imem_req_valid = !rst && (state == FS_FETCH) && !redirect_valid;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= FS_FETCH;
         pc_f       <= RESET_PC;
         req_pc     <= RESET_PC;
         drop       <= 1'b0;
         hold_instr <= NOP_INSTR;
         hold_pc    <= RESET_PC;
      end else begin
         case (state)
            FS_FETCH: begin
               if (redirect_valid) begin
                  pc_f <= target;
               end else if (imem_req_ready) begin
                  req_pc <= pc_f;
                  pc_f   <= pc_f + 32'd4;
                  state  <= FS_WAIT;
               end
            end
            FS_WAIT: begin
               if (redirect_valid) begin
                  pc_f <= target;
                  // the in-flight response is still owed; remember to swallow it
                  if (imem_rsp_valid) begin
                     drop  <= 1'b0;
                     state <= FS_FETCH;
                  end else begin
                     drop <= 1'b1;
                  end
               end else if (imem_rsp_valid) begin
                  if (drop) begin
                     drop  <= 1'b0;
                     state <= FS_FETCH;
                  end else if (stall_ID) begin
                     hold_instr <= imem_rsp_data;
                     hold_pc    <= req_pc;
                     state      <= FS_HOLD;
                  end else begin
                     state <= FS_FETCH;
                  end
               end
            end
            FS_HOLD: begin
               if (redirect_valid) begin
                  pc_f  <= target;
                  state <= FS_FETCH;
               end else if (!stall_ID) begin
                  state <= FS_FETCH;
               end
            end
            default: state <= FS_FETCH;
         endcase
      end
   end

   always_comb begin
      deliver       = 1'b0;
      deliver_instr = imem_rsp_data;
      deliver_pc    = req_pc;
      case (state)
         FS_WAIT: deliver = imem_rsp_valid && !drop && !redirect_valid && !stall_ID;
         FS_HOLD: begin
            deliver       = !redirect_valid && !stall_ID;
            deliver_instr = hold_instr;
            deliver_pc    = hold_pc;
         end
         default: deliver = 1'b0;
      endcase
   end

   if_id_reg #(
      .RESET_PC  (RESET_PC),
      .NOP_INSTR (NOP_INSTR)
   ) u_if_id (
      .clk        (clk),
      .rst        (rst),
      .flush      (redirect_valid),
      .stall      (stall_ID),
      .load       (deliver),
      .load_instr (deliver_instr),
      .load_pc    (deliver_pc),
      .instr      (instr_ID),
      .pc         (pc_ID),
      .pc4        (pc4_ID),
      .valid      (valid_ID)
   );
endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed and randomized checks of fetch_stage against a transaction-level model
module tb_fetch_stage;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk;
   logic        rst;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        stall_ID;
   logic [31:0] instr_ID;
   logic [31:0] pc_ID;
   logic [31:0] pc4_ID;
   logic        valid_ID;

   fetch_stage dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_addr      (imem_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .stall_ID       (stall_ID),
      .instr_ID       (instr_ID),
      .pc_ID          (pc_ID),
      .pc4_ID         (pc4_ID),
      .valid_ID       (valid_ID)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_asrt = 0;
   int          n_fail = 0;
   logic        pend;
   logic [31:0] pend_addr;
   int          pend_cnt;
   logic [31:0] exp_pc;
   logic [31:0] exp_req;
   logic        acc_seen;
   logic        req_seen;
   logic [31:0] addr_seen;
   logic        stray;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0:   return 32'h0050_0093;
         32'h4:   return 32'h0010_0113;
         default: return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs, sample the request mid-cycle, then score the edge.
   task automatic cycle(input logic rdy, input logic stl, input logic rdr,
                        input logic [31:0] rpc, input int lat);
      logic        gave;
      logic [31:0] p_instr, p_pc, p_pc4;
      logic        p_valid;
      p_instr = instr_ID; p_pc = pc_ID; p_pc4 = pc4_ID; p_valid = valid_ID;
      imem_req_ready = rdy;
      stall_ID       = stl;
      redirect_valid = rdr;
      redirect_pc    = rpc;
      gave           = pend && (pend_cnt == 0);
      imem_rsp_valid = gave || stray;
      imem_rsp_data  = gave ? mem_word(pend_addr) : 32'hDEAD_BEEF;
      #2;
      req_seen  = imem_req_valid;
      addr_seen = imem_addr;
      acc_seen  = req_seen && rdy;
      @(posedge clk);
      #1;
      imem_rsp_valid = 1'b0;
      stray          = 1'b0;
      if (acc_seen) begin
         chk("one_outstanding", 32'(pend && !gave), 32'd0);
         chk("req_addr", addr_seen, exp_req);
         exp_req = exp_req + 32'd4;
      end
      if (gave) pend = 1'b0;
      else if (pend) pend_cnt--;
      if (acc_seen) begin
         pend      = 1'b1;
         pend_addr = addr_seen;
         pend_cnt  = lat;
      end
      if (rdr) begin
         chk("flush_valid", 32'(valid_ID), 32'd0);
         chk("flush_instr", instr_ID, NOP);
         exp_pc  = {rpc[31:2], 2'b00};
         exp_req = {rpc[31:2], 2'b00};
      end else if (stl) begin
         chk("stall_instr", instr_ID, p_instr);
         chk("stall_pc", pc_ID, p_pc);
         chk("stall_pc4", pc4_ID, p_pc4);
         chk("stall_valid", 32'(valid_ID), 32'(p_valid));
      end else if (valid_ID) begin
         chk("deliver_pc", pc_ID, exp_pc);
         chk("deliver_instr", instr_ID, mem_word(exp_pc));
         chk("deliver_pc4", pc4_ID, exp_pc + 32'd4);
         exp_pc = exp_pc + 32'd4;
      end else begin
         chk("bubble_instr", instr_ID, NOP);
      end
   endtask

   initial begin
      rst = 1'b1;
      imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
      redirect_valid = 1'b0; redirect_pc = 32'h0; stall_ID = 1'b0;
      pend = 1'b0; pend_addr = 32'h0; pend_cnt = 0; stray = 1'b0;
      exp_pc = 32'h0; exp_req = 32'h0;
      acc_seen = 1'b0; req_seen = 1'b0; addr_seen = 32'h0;

      @(posedge clk); #1;
      chk("rst_valid", 32'(valid_ID), 32'd0);
      chk("rst_instr", instr_ID, NOP);
      chk("rst_pc", pc_ID, 32'h0);
      chk("rst_pc4", pc4_ID, 32'h4);
      chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
      rst = 1'b0;
      #1;
      chk("post_rst_req_valid", 32'(imem_req_valid), 32'd1);
      chk("post_rst_addr", imem_addr, 32'h0);
      @(posedge clk); #1;
      rst = 1'b1; @(posedge clk); #1; rst = 1'b0;

      // sequential fetch, one-cycle memory
      cycle(1, 0, 0, 0, 0);
      chk("seq_acc0", 32'(acc_seen), 32'd1);
      cycle(1, 0, 0, 0, 0);
      chk("seq_valid0", 32'(valid_ID), 32'd1);
      chk("seq_instr0", instr_ID, 32'h0050_0093);
      chk("seq_pc4_0", pc4_ID, 32'h4);
      cycle(1, 0, 0, 0, 0);
      chk("seq_bubble", 32'(valid_ID), 32'd0);
      cycle(1, 0, 0, 0, 0);
      chk("seq_instr1", instr_ID, 32'h0010_0113);
      chk("seq_pc1", pc_ID, 32'h4);
      chk("seq_pc4_1", pc4_ID, 32'h8);

      // decode stall while the response lands
      cycle(1, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         cycle(1, 1, 0, 0, 0);
         chk("stall_no_req", 32'(req_seen), 32'd0);
      end
      cycle(1, 0, 0, 0, 2);
      chk("hold_release_valid", 32'(valid_ID), 32'd1);
      chk("hold_release_pc", pc_ID, 32'h8);
      cycle(1, 0, 0, 0, 2);
      chk("resume_addr", addr_seen, 32'hC);

      // redirect in WAIT, stale response arrives two cycles later
      cycle(1, 0, 1, 32'h100, 0);
      cycle(1, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0);
      chk("drop_valid", 32'(valid_ID), 32'd0);
      cycle(1, 0, 0, 0, 0);
      chk("redir_addr", addr_seen, 32'h100);
      cycle(1, 0, 0, 0, 0);
      chk("redir_pc", pc_ID, 32'h100);

      // redirect, response and stall together
      cycle(1, 0, 0, 0, 0);
      cycle(1, 1, 1, 32'h300, 0);
      cycle(1, 0, 0, 0, 0);
      chk("redir2_addr", addr_seen, 32'h300);
      cycle(1, 0, 0, 0, 0);

      // memory not ready, then misaligned redirect target
      for (int i = 0; i < 4; i++) begin
         cycle(0, 0, 0, 0, 0);
         chk("nordy_req_valid", 32'(req_seen), 32'd1);
         chk("nordy_addr", addr_seen, 32'h304);
      end
      cycle(0, 0, 1, 32'h203, 0);
      chk("align_addr", imem_addr, 32'h200);
      cycle(1, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0);

      // PC wrap
      cycle(1, 0, 1, 32'hFFFF_FFFC, 0);
      cycle(1, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0);
      chk("wrap_pc4", pc4_ID, 32'h0);
      chk("wrap_next_addr", imem_addr, 32'h0);
      cycle(1, 0, 0, 0, 3);
      chk("wrap_acc_addr", addr_seen, 32'h0);

      // asynchronous reset while a request is outstanding
      #2; rst = 1'b1; #1;
      chk("arst_valid", 32'(valid_ID), 32'd0);
      chk("arst_instr", instr_ID, NOP);
      chk("arst_pc4", pc4_ID, 32'h4);
      chk("arst_req_valid", 32'(imem_req_valid), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      pend = 1'b0; exp_pc = 32'h0; exp_req = 32'h0;
      stray = 1'b1;
      cycle(0, 0, 0, 0, 0);
      chk("stray_ignored", 32'(valid_ID), 32'd0);
      cycle(1, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0);
      chk("after_rst_pc", pc_ID, 32'h0);

      // randomized traffic scored by the model
      for (int i = 0; i < 400; i++) begin
         cycle(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) < 3),
               1'($urandom_range(0, 19) == 0), $urandom, int'($urandom_range(0, 3)));
      end
      for (int i = 0; i < 12; i++) cycle(1, 0, 0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end
endmodule
